// File: rtl/cacc_pkg.sv
// Shared types and constants for the complex accumulate/requantise stage.
package cacc_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx32_t;

    typedef enum logic [1:0] {
        ACCUM,
        ROUND,
        HOLD
    } cacc_state_e;

    localparam int Q15_MAX = 32767;
    localparam int Q15_MIN = -32768;

    // Beat counter width; a single-beat frame still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cacc_requant.sv
// Combinational round-half-up, arithmetic shift and Q1.15 saturation of one
// accumulator component.
module cacc_requant
    import cacc_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [15:0]      o_y,
    output logic                    o_clip
);

    // One guard bit so the rounding bias can never wrap a near-full accumulator.
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT-1);

    logic signed [ACC_W:0] w_biased;
    logic signed [ACC_W:0] w_shifted;

    always_comb begin
        w_biased  = (ACC_W+1)'(i_acc) + RND;
        w_shifted = w_biased >>> SHIFT;
        o_y       = w_shifted[15:0];
        o_clip    = 1'b0;
        if (w_shifted > (ACC_W+1)'(Q15_MAX)) begin
            o_y    = 16'(Q15_MAX);
            o_clip = 1'b1;
        end else if (w_shifted < (ACC_W+1)'(Q15_MIN)) begin
            o_y    = 16'(Q15_MIN);
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/complex_accum_requant.sv
// Frame accumulator for Q2.30 complex products with Q1.15 requantised output.
// Optional macro CACC_SAT_CNT_EN adds the sat_count port.
module complex_accum_requant
    import cacc_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int ACC_W     = 40,
    parameter int SHIFT     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat
`ifdef CACC_SAT_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);

    localparam int CNT_W = cnt_width(FRAME_LEN);

    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("FRAME_LEN must be >= 1");
    end
    if (ACC_W < 32 + $clog2(FRAME_LEN) + 1) begin : g_bad_acc_w
        $error("ACC_W too small for FRAME_LEN products");
    end
    if (SHIFT < 1 || SHIFT > ACC_W - 16) begin : g_bad_shift
        $error("SHIFT must be in 1..ACC_W-16");
    end

    cacc_state_e             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    cplx16_t                 r_out_data;
    logic                    r_out_sat;
    logic                    r_out_valid;

    cplx32_t                 w_in;
    logic signed [15:0]      w_y_re;
    logic signed [15:0]      w_y_im;
    logic                    w_clip_re;
    logic                    w_clip_im;
    logic                    w_last;

    assign w_in      = in_data;
    assign w_last    = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign in_ready  = (r_state == ACCUM) && !clear;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    cacc_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_rq_re (
        .i_acc  (r_acc_re),
        .o_y    (w_y_re),
        .o_clip (w_clip_re)
    );

    cacc_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_rq_im (
        .i_acc  (r_acc_im),
        .o_y    (w_y_im),
        .o_clip (w_clip_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        r_acc_re <= r_acc_re + ACC_W'(w_in.re);
                        r_acc_im <= r_acc_im + ACC_W'(w_in.im);
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ROUND;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ROUND: begin
                    r_out_data  <= '{re: w_y_re, im: w_y_im};
                    r_out_sat   <= w_clip_re | w_clip_im;
                    r_out_valid <= 1'b1;
                    r_acc_re    <= '0;
                    r_acc_im    <= '0;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

`ifdef CACC_SAT_CNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (clear) begin
            r_sat_count <= '0;
        end else if (r_out_valid && out_ready && r_out_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_complex_accum_requant.sv
// Self-checking bench: FRAME_LEN=4 instance for framing/backpressure/reset,
// FRAME_LEN=1 instance for rounding, both against an arithmetic model.
module tb_complex_accum_requant;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
    logic [63:0] a_in_data;
    logic [31:0] a_out_data;
    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
    logic [63:0] b_in_data;
    logic [31:0] b_out_data;
`ifdef CACC_SAT_CNT_EN
    logic [15:0] a_sat_count, b_sat_count;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_sc = '0;

    always #5 clk = ~clk;

    complex_accum_requant #(.FRAME_LEN(4), .ACC_W(40), .SHIFT(15)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_sat(a_out_sat)
`ifdef CACC_SAT_CNT_EN
        , .sat_count(a_sat_count)
`endif
    );

    complex_accum_requant #(.FRAME_LEN(1), .ACC_W(40), .SHIFT(15)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_sat(b_out_sat)
`ifdef CACC_SAT_CNT_EN
        , .sat_count(b_sat_count)
`endif
    );

    // Reference: floor((sum + 2^14) / 2^15), then clip to Q1.15. Returns {clip, y}.
    function automatic logic [16:0] rq(input longint s);
        longint t, y;
        logic   c;
        t = s + 64'sd16384;
        if (t >= 0) y = t / 32768;
        else        y = -((-t + 32767) / 32768);
        c = 1'b0;
        if (y > 32767)       begin y = 32767;  c = 1'b1; end
        else if (y < -32768) begin y = -32768; c = 1'b1; end
        return {c, y[15:0]};
    endfunction

    function automatic void frame_exp(input longint sre, input longint sim,
                                      output logic [31:0] d, output logic s);
        logic [16:0] r, i;
        r = rq(sre);
        i = rq(sim);
        d = {r[15:0], i[15:0]};
        s = r[16] | i[16];
    endfunction

    function automatic logic [31:0] rnd_word();
        int unsigned sh;
        sh = $urandom_range(0, 24);
        return 32'($signed($urandom) >>> sh);
    endfunction

    function automatic longint sx(input logic [31:0] w);
        return longint'($signed(w));
    endfunction

    task automatic a_send(input logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL a_send_timeout: in_ready=%b required 1", a_in_ready);
            a_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 a_in_valid = 1'b0;
    endtask

    task automatic a_result(input logic [31:0] ed, input logic es, input int hold, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_out_valid && n < 60);
        tests_run++;
        if (!a_out_valid) begin
            tests_failed++;
            $display("FAIL %s_timeout: out_valid=%b required 1", nm, a_out_valid);
            return;
        end
        tests_run++;
        if (a_out_data !== ed) begin
            tests_failed++;
            $display("FAIL %s_data: got %h required %h", nm, a_out_data, ed);
        end
        tests_run++;
        if (a_out_sat !== es) begin
            tests_failed++;
            $display("FAIL %s_sat: got %b required %b", nm, a_out_sat, es);
        end
        repeat (hold) begin
            @(negedge clk);
            tests_run++;
            if (a_out_data !== ed || a_out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_hold: data %h valid %b required %h 1", nm, a_out_data, a_out_valid, ed);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (es && exp_sc != 16'hFFFF) exp_sc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid %b data %h sat %b required 0 0 0", a_out_valid, a_out_data, a_out_sat);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: a %b b %b required 1 1", a_in_ready, b_in_ready);
        end
        tests_run++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: a %b b %b required 0 0", a_out_valid, b_out_valid);
        end
`ifdef CACC_SAT_CNT_EN
        tests_run++;
        if (a_sat_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_sat_count: got %h required 0000", a_sat_count);
        end
`endif
        exp_sc = '0;
    endtask

    task automatic test_basic();
        a_out_ready = 1'b1;
        repeat (4) a_send({32'sd32768, 32'sd0});
        // Last beat has just been taken: ROUND now, result registers on the next edge.
        tests_run++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_round_cycle: valid %b in_ready %b required 0 0", a_out_valid, a_in_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (a_out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_latency: out_valid=%b required 1", a_out_valid);
        end
        a_result(32'h0004_0000, 1'b0, 0, "basic");
    endtask

    task automatic test_rounding();
        logic [31:0] vin  [4] = '{32'sd16384, 32'sd16383, -32'sd16384, -32'sd16385};
        logic [31:0] vexp [4] = '{32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_0001};
        logic [31:0] ed, rr, ii;
        logic        es;
        int          n;
        b_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                rr = vin[i];
                ii = -vin[i];
                ed = vexp[i];
                es = 1'b0;
            end else begin
                rr = rnd_word();
                ii = rnd_word();
                frame_exp(sx(rr), sx(ii), ed, es);
            end
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_data  = {rr, ii};
            n = 0;
            while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk);
            #1 b_in_valid = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!b_out_valid && n < 20);
            tests_run++;
            if (b_out_valid !== 1'b1 || b_out_data !== ed || b_out_sat !== es) begin
                tests_failed++;
                $display("FAIL round_%0d: valid %b data %h sat %b required 1 %h %b",
                         i, b_out_valid, b_out_data, b_out_sat, ed, es);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        a_out_ready = 1'b1;
        repeat (4) a_send({32'h3FFF_FFFF, 32'hC000_0000});
        a_result(32'h7FFF_8000, 1'b1, 0, "sat");
`ifdef CACC_SAT_CNT_EN
        @(negedge clk);
        tests_run++;
        if (a_sat_count !== exp_sc) begin
            tests_failed++;
            $display("FAIL sat_count: got %h required %h", a_sat_count, exp_sc);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] rr [4];
        logic [31:0] ii [4];
        longint      sre, sim;
        logic [31:0] ed;
        logic        es;
        int          n;
        sre = 0; sim = 0;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rr[i] = rnd_word();
            ii[i] = rnd_word();
            sre += sx(rr[i]);
            sim += sx(ii[i]);
            a_send({rr[i], ii[i]});
        end
        frame_exp(sre, sim, ed, es);
        n = 0;
        do begin @(negedge clk); n++; end while (!a_out_valid && n < 20);
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (a_out_valid !== 1'b1 || a_out_data !== ed || a_out_sat !== es || a_in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stall_%0d: valid %b data %h sat %b in_ready %b required 1 %h %b 0",
                         c, a_out_valid, a_out_data, a_out_sat, a_in_ready, ed, es);
            end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        if (es && exp_sc != 16'hFFFF) exp_sc++;
        @(negedge clk);
        tests_run++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== ed) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready %b valid %b data %h required 1 0 %h",
                     a_in_ready, a_out_valid, a_out_data, ed);
        end
    endtask

    task automatic test_clear();
        a_out_ready = 1'b1;
        repeat (2) a_send({32'sd32768, 32'sd0});
        @(negedge clk);
        a_clear    = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = {32'sd99999, 32'sd77777};
        #1;
        tests_run++;
        if (a_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_in_ready: got %b required 0", a_in_ready);
        end
        @(posedge clk);
        #1;
        a_clear    = 1'b0;
        a_in_valid = 1'b0;
        exp_sc     = '0;
`ifdef CACC_SAT_CNT_EN
        tests_run++;
        if (a_sat_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL clear_sat_count: got %h required 0000", a_sat_count);
        end
`endif
        repeat (4) a_send({32'sd65536, 32'sd0});
        a_result(32'h0008_0000, 1'b0, 0, "clear");
    endtask

    task automatic test_random();
        logic [31:0] rr, ii, ed;
        logic        es;
        longint      sre, sim;
        for (int f = 0; f < 8; f++) begin
            sre = 0; sim = 0;
            a_out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                rr = rnd_word();
                ii = rnd_word();
                sre += sx(rr);
                sim += sx(ii);
                a_send({rr, ii});
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
            frame_exp(sre, sim, ed, es);
            a_result(ed, es, int'($urandom_range(0, 3)), $sformatf("rand%0d", f));
        end
`ifdef CACC_SAT_CNT_EN
        @(negedge clk);
        tests_run++;
        if (a_sat_count !== exp_sc) begin
            tests_failed++;
            $display("FAIL rand_sat_count: got %h required %h", a_sat_count, exp_sc);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] ed;
        logic        es;
        a_out_ready = 1'b0;
        repeat (4) a_send({32'sd32768, 32'sd32768});
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_rst: valid %b data %h sat %b required 0 0 0", a_out_valid, a_out_data, a_out_sat);
        end
        exp_sc = '0;
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) a_send({-32'sd32768, 32'sd49152});
        frame_exp(-64'sd131072, 64'sd196608, ed, es);
        a_result(ed, es, 0, "post_rst");
    endtask

    initial begin
        rst = 1'b1;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_clear();
        test_random();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
